// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds and sticky error flags.
// Define SYNC_FIFO_FWFT_EN to get first-word-fall-through reads; the default is a registered 1-cycle read.
module sync_fifo_flags #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wen,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   ren,
  input  logic                   clr_err,
  output logic [WIDTH-1:0]       rdata,
  output logic                   rvalid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] PTR_ONE = CW'(1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          afull_q, afull_d;
  logic          aempty_q, aempty_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          wr_acc, rd_acc;
  logic [AW-1:0] rd_addr;

  // Acceptance is judged on pre-edge flags, so a same-cycle pop never makes room for a push.
  assign wr_acc  = wen && !full_q;
  assign rd_acc  = ren && !empty_q;
  assign rd_addr = rd_ptr_q[AW-1:0];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
    // Wrap bits make the modular difference span 0..DEPTH exactly.
    count_d  = wr_ptr_d - rd_ptr_d;
    full_d   = (count_d == DEPTH_C);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AF_C);
    aempty_d = (count_d <= AE_C);

    ovf_d = ovf_q;
    udf_d = udf_q;
    if (clr_err) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (wen && full_q)  ovf_d = 1'b1;
    if (ren && empty_q) udf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is deliberately left out of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rdata  = mem_q[rd_addr];
  assign rvalid = !empty_q;
`else
  logic [WIDTH-1:0] rdata_q;
  logic             rvalid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_acc;
      if (rd_acc) rdata_q <= mem_q[rd_addr];
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
`endif

  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed self-checking bench for sync_fifo_flags (WIDTH=8, DEPTH=16, AF=12, AE=4).
module tb_sync_fifo_flags;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wen = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       ren = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rdata;
  logic       rvalid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  int errors = 0;
  int checks = 0;

  sync_fifo_flags #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(4)) dut (
    .clk(clk), .rst(rst), .wen(wen), .wdata(wdata), .ren(ren), .clr_err(clr_err),
    .rdata(rdata), .rvalid(rvalid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // One rising edge, then settle 1ns so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen = 1'b0; ren = 1'b0; clr_err = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    #12;
    checks++; if (count !== 5'd0)      begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1)      begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_aempty got=%b exp=1", almost_empty); end
    checks++; if (full !== 1'b0)       begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_afull got=%b exp=0", almost_full); end
    checks++; if (overflow !== 1'b0)   begin errors++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    checks++; if (underflow !== 1'b0)  begin errors++; $display("FAIL reset_udf got=%b exp=0", underflow); end
    checks++; if (rvalid !== 1'b0)     begin errors++; $display("FAIL reset_rvalid got=%b exp=0", rvalid); end
`ifndef SYNC_FIFO_FWFT_EN
    checks++; if (rdata !== 8'h00)     begin errors++; $display("FAIL reset_rdata got=%h exp=00", rdata); end
`endif
    @(negedge clk);
    rst = 1'b0;
    step();
    $display("reset: count=%0d empty=%b", count, empty);
  endtask

`ifndef SYNC_FIFO_FWFT_EN
  task automatic test_fill_drain();
    for (int i = 1; i <= 16; i++) begin
      wen = 1'b1; wdata = 8'(i);
      step();
      checks++; if (count !== 5'(i)) begin errors++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, count, i); end
      checks++; if (almost_empty !== (i <= 4)) begin errors++; $display("FAIL fill_aempty i=%0d got=%b exp=%b", i, almost_empty, (i <= 4)); end
      checks++; if (almost_full !== (i >= 12)) begin errors++; $display("FAIL fill_afull i=%0d got=%b exp=%b", i, almost_full, (i >= 12)); end
      checks++; if (full !== (i == 16)) begin errors++; $display("FAIL fill_full i=%0d got=%b exp=%b", i, full, (i == 16)); end
      $display("write %02h count=%0d", wdata, count);
    end
    idle();
    for (int i = 1; i <= 16; i++) begin
      ren = 1'b1;
      step();
      checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL drain_rvalid i=%0d got=%b exp=1", i, rvalid); end
      checks++; if (rdata !== 8'(i)) begin errors++; $display("FAIL drain_rdata i=%0d got=%h exp=%h", i, rdata, 8'(i)); end
      checks++; if (count !== 5'(16 - i)) begin errors++; $display("FAIL drain_count i=%0d got=%0d exp=%0d", i, count, 16 - i); end
      $display("read %02h count=%0d", rdata, count);
    end
    idle();
    step();
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL drain_rvalid_idle got=%b exp=0", rvalid); end
    checks++; if (empty !== 1'b1)  begin errors++; $display("FAIL drain_empty got=%b exp=1", empty); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 16; i++) begin
      wen = 1'b1; wdata = 8'(8'h20 + i);
      step();
    end
    wen = 1'b1; wdata = 8'hAA; ren = 1'b1;
    step();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    checks++; if (count !== 5'd15)   begin errors++; $display("FAIL ovf_count got=%0d exp=15", count); end
    checks++; if (rdata !== 8'h21)   begin errors++; $display("FAIL ovf_first got=%h exp=21", rdata); end
    $display("overflow write AA rejected count=%0d", count);
    idle();
    for (int i = 2; i <= 16; i++) begin
      ren = 1'b1;
      step();
      checks++; if (rdata !== 8'(8'h20 + i)) begin errors++; $display("FAIL ovf_read i=%0d got=%h exp=%h", i, rdata, 8'(8'h20 + i)); end
    end
    idle();
    step();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_empty got=%b exp=1", empty); end
  endtask

  task automatic test_clr_err();
    clr_err = 1'b1;
    step();
    idle();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_ovf got=%b exp=0", overflow); end
    for (int i = 0; i < 16; i++) begin
      wen = 1'b1; wdata = 8'(8'h50 + i);
      step();
    end
    wen = 1'b1; wdata = 8'hEE;
    step();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL clr_reset_ovf got=%b exp=1", overflow); end
    wen = 1'b1; clr_err = 1'b1;
    step();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL clr_set_wins got=%b exp=1", overflow); end
    idle();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_again got=%b exp=0", overflow); end
    $display("clr_err: overflow=%b", overflow);
    for (int i = 0; i < 16; i++) begin
      ren = 1'b1;
      step();
      checks++; if (rdata !== 8'(8'h50 + i)) begin errors++; $display("FAIL clr_read i=%0d got=%h exp=%h", i, rdata, 8'(8'h50 + i)); end
    end
    idle();
    step();
  endtask

  task automatic test_underflow();
    ren = 1'b1; wen = 1'b1; wdata = 8'h5C;
    step();
    idle();
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL udf_set got=%b exp=1", underflow); end
    checks++; if (rvalid !== 1'b0)    begin errors++; $display("FAIL udf_rvalid got=%b exp=0", rvalid); end
    checks++; if (count !== 5'd1)     begin errors++; $display("FAIL udf_count got=%0d exp=1", count); end
    ren = 1'b1;
    step();
    idle();
    checks++; if (rdata !== 8'h5C || rvalid !== 1'b1) begin errors++; $display("FAIL udf_read got=%h/%b exp=5c/1", rdata, rvalid); end
    $display("underflow: read %02h", rdata);
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      wen = 1'b1; wdata = 8'(8'h40 + i);
      step();
    end
    for (int k = 0; k < 40; k++) begin
      wen = 1'b1; ren = 1'b1; wdata = 8'(8'h48 + k);
      step();
      checks++; if (count !== 5'd8) begin errors++; $display("FAIL b2b_count k=%0d got=%0d exp=8", k, count); end
      checks++; if (rdata !== 8'(8'h40 + k) || rvalid !== 1'b1) begin errors++; $display("FAIL b2b_rdata k=%0d got=%h exp=%h", k, rdata, 8'(8'h40 + k)); end
    end
    idle();
    for (int j = 0; j < 8; j++) begin
      ren = 1'b1;
      step();
      checks++; if (rdata !== 8'(8'h68 + j)) begin errors++; $display("FAIL b2b_tail j=%0d got=%h exp=%h", j, rdata, 8'(8'h68 + j)); end
    end
    idle();
    step();
    $display("back_to_back: final count=%0d", count);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 9; i++) begin
      wen = 1'b1; wdata = 8'(8'h90 + i);
      step();
    end
    wen = 1'b1; ren = 1'b1; wdata = 8'h99;
    step();
    idle();
    checks++; if (count !== 5'd9 || rvalid !== 1'b1) begin errors++; $display("FAIL arst_pre got=%0d/%b exp=9/1", count, rvalid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (count !== 5'd0)  begin errors++; $display("FAIL arst_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1)  begin errors++; $display("FAIL arst_empty got=%b exp=1", empty); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL arst_rvalid got=%b exp=0", rvalid); end
    #2 rst = 1'b0;
    wen = 1'b1; wdata = 8'h33;
    step();
    wen = 1'b0; ren = 1'b1;
    step();
    idle();
    checks++; if (rdata !== 8'h33 || rvalid !== 1'b1) begin errors++; $display("FAIL arst_read got=%h/%b exp=33/1", rdata, rvalid); end
    $display("async reset: read back %02h", rdata);
  endtask
`else
  task automatic test_fwft();
    wen = 1'b1; wdata = 8'h7E;
    step();
    idle();
    checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL fwft_rvalid got=%b exp=1", rvalid); end
    checks++; if (rdata !== 8'h7E) begin errors++; $display("FAIL fwft_rdata got=%h exp=7e", rdata); end
    checks++; if (count !== 5'd1)  begin errors++; $display("FAIL fwft_count got=%0d exp=1", count); end
    ren = 1'b1;
    step();
    idle();
    checks++; if (empty !== 1'b1)  begin errors++; $display("FAIL fwft_empty got=%b exp=1", empty); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL fwft_pop_rvalid got=%b exp=0", rvalid); end
    $display("fwft: popped 7e, empty=%b", empty);
  endtask
`endif

  initial begin
    test_reset();
`ifndef SYNC_FIFO_FWFT_EN
    test_fill_drain();
    test_overflow();
    test_clr_err();
    test_underflow();
    test_back_to_back();
    test_async_reset();
`else
    test_fwft();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
- Single-clock, parametrised FIFO; successor to the dual-clock FIFO for same-domain buffering.
- Adds the following:
  - occupancy count
  - programmable almost-full and almost-empty thresholds
  - sticky overflow and underflow error flags
  - a read-valid strobe
  - an optional first-word-fall-through read mode
- Sits between a producer and a consumer on the same clock, e.g. between packet parser and output serializer.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 16, number of entries; power of two, >= 4.
- AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL; range 1..DEPTH.
- AE_LEVEL, 4, almost_empty asserts when count <= AE_LEVEL; range 0..DEPTH-1.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- wen  input  1  write request.
- wdata  input  WIDTH  write data.
- ren  input  1  read request (in FWFT mode, read acknowledge).
- clr_err  input  1  synchronous clear of overflow/underflow.
- rdata  output  WIDTH  read data.
- rvalid  output  1  rdata valid.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_LEVEL.
- almost_empty  output  1  count <= AE_LEVEL.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: write attempted while full.
- underflow  output  1  sticky: read attempted while empty.

Behaviour:
- Reset (rst high, asynchronous, held until deasserted):
  - pointers = 0, count = 0, rdata = 0, rvalid = 0
  - empty = 1, almost_empty = 1
  - full = 0, almost_full = 0, overflow = 0, underflow = 0
  - Memory contents are not reset.
  - Reset mid-operation discards all stored words; the first post-reset read returns the first post-reset write.
- Pointers: write and read pointers are $clog2(DEPTH)+1 bits binary; the extra MSB is the wrap bit. Address = low $clog2(DEPTH) bits. Pointers wrap naturally at 2*DEPTH.
- Write accept: wen && !full, sampled at the rising edge. wdata is stored at the write address, then the write pointer increments.
- Read accept: ren && !empty, sampled at the rising edge; the read pointer increments.
- Flags use pre-edge state:
  - Write while full is rejected even if a read is accepted in the same cycle.
  - Read while empty is rejected even if a write is accepted in the same cycle.
- Simultaneous accepted read and write: count unchanged; both pointers advance.
- count, full, empty, almost_full and almost_empty are registered and derived from next-state count. All update on the same edge as the accepting transfer; no extra cycle of lag.
- Errors:
  - overflow sets on the edge where wen && full.
  - underflow sets on the edge where ren && empty.
  - Both hold until clr_err. If clr_err coincides with a new error event, set wins.
- Standard read mode (macro absent):
  - On an accepted read, rdata is loaded with the head word at that edge, and rvalid = 1 for exactly that following cycle.
  - Read latency is 1 cycle.
  - With no accepted read, rvalid = 0 and rdata holds its last value.
  - Back-to-back reads give one word per cycle.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined:
  - rdata continuously presents the head word (combinational from memory at the read address); rvalid = !empty.
  - ren acts as acknowledge: accepted ren pops the head, and the next word appears after that edge.
  - A word written into an empty FIFO is visible on rdata, with rvalid = 1, after the write edge (latency 1).
  - Reset value of rvalid is 0; rdata is don't-care while rvalid = 0.
- Undefined: standard mode as above.
- Counts, flags and errors are identical in both modes.

Test Plan:
- Reset, then write 0x01..0x10 on 16 consecutive cycles:
  - count steps 1..16; almost_empty drops after write 5; almost_full rises after write 12; full = 1 after write 16.
  - Then 16 reads: rdata = 0x01..0x10 in order, each with rvalid = 1 the cycle after its ren; empty = 1 after the last read.
- Full FIFO, wen = 1 with wdata = 0xAA, and ren = 1 in the same cycle: write rejected, overflow = 1, count becomes 15. A later read sequence never returns 0xAA.
- Empty FIFO, ren = 1 and wen = 1 (wdata = 0x5C) in the same cycle: read rejected, underflow = 1, rvalid stays 0, count = 1. The next read returns 0x5C.
- Fill 8, then 40 cycles of simultaneous wen/ren with an incrementing pattern: count holds at 8 throughout; output order is preserved across pointer wrap.
- overflow = 1, then pulse clr_err: overflow = 0 next cycle. Pulse clr_err in the same cycle as another wen-while-full: overflow stays 1.
- Assert rst mid-burst at count = 9 (asynchronous, between edges): count = 0, empty = 1, rvalid = 0 immediately. After release, write 0x33 and read it back as 0x33.
- FWFT build: write 0x7E into an empty FIFO. rvalid = 1 and rdata = 0x7E the cycle after the write, with no ren. Assert ren: empty = 1 and rvalid = 0 after that edge.
